// File: rtl/input_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// input_rr_arbiter_pkg
//   Shared definitions for the packet round-robin input arbiter.
//   - arb_state_t : arbiter FSM encoding (PICK = 0, XFER = 1)
//   - arb_regs_t  : the complete arbiter register set (FSM state, current
//                   grant, round-robin pointer). The FSM state is exposed
//                   through this struct.
//   - log2_ceil   : ceiling log2 for elaboration-time width computation
//   - fifo_word_width : width of one buffered word {tlast, tuser, tstrb, tdata}
// ----------------------------------------------------------------------------
package input_rr_arbiter_pkg;

  typedef enum logic [0:0] {
    PICK = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Grant and pointer fields are sized for the largest supported input
  // count (8), so the struct does not depend on a parameter.
  localparam int PORT_IDX_W = 3;
  localparam int MAX_INPUTS = 8;

  typedef struct packed {
    arb_state_t              state;
    logic [PORT_IDX_W-1:0]   grant;
    logic [PORT_IDX_W-1:0]   rr_ptr;
  } arb_regs_t;

  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int fifo_word_width(input int dw, input int uw);
    return dw + uw + (dw / 8) + 1;
  endfunction

endpackage

// File: rtl/input_rr_arbiter_fifo.sv
// ----------------------------------------------------------------------------
// fallthrough_small_fifo
//   Small first-word-fall-through FIFO: the oldest stored word is always
//   visible on dout while empty = 0; rd_en pops it at the clock edge.
//   Ports:
//     clk         clock
//     reset       asynchronous, active-high; flushes the FIFO
//     din/wr_en   write port (write ignored when the FIFO is full)
//     rd_en       pop the head word (ignored when empty)
//     dout        head word
//     nearly_full asserted when only one free slot remains (or none)
//     empty       no word stored
//   A simultaneous write and read is legal; a word written into an empty
//   FIFO becomes visible on the following cycle.
// ----------------------------------------------------------------------------
module fallthrough_small_fifo #(
  parameter int WIDTH          = 8,
  parameter int MAX_DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] DEPTH_CNT = (MAX_DEPTH_BITS + 1)'(DEPTH);

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   count;
  logic                      do_wr;
  logic                      do_rd;

  assign do_wr = wr_en & (count != DEPTH_CNT);
  assign do_rd = rd_en & (count != '0);

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout        = mem[rd_ptr];
  assign empty       = (count == '0);
  // Ready is derived combinationally from this flag, so it must drop one
  // slot early to leave room for the word accepted in the same cycle.
  assign nearly_full = (count >= (DEPTH_CNT - 1'b1));

endmodule

// File: rtl/input_rr_arbiter.sv
// ----------------------------------------------------------------------------
// input_rr_arbiter
//   Packet-granular round-robin arbiter merging NUM_INPUTS AXI4-Stream inputs
//   into one output stream. Every input is buffered in a small fall-through
//   FIFO; whole packets are forwarded atomically, with tuser/tstrb/tlast
//   passed through unchanged.
//   Ports:
//     axi_aclk, axi_resetn   clock, asynchronous active-low reset
//     s_axis_*               flattened input buses, input i at [i*W +: W]
//     s_axis_tready          per-input ready (= FIFO not nearly full)
//     m_axis_*               merged output stream
//   Handshake: a beat transfers on any clock edge where tvalid & tready are
//   both high; the sender keeps tdata/tstrb/tuser/tlast stable while
//   tvalid = 1 and tready = 0, and never withdraws tvalid before transfer.
//   The arbiter drops m_axis_tvalid only when the granted FIFO runs empty.
//   FSM:
//     PICK : scan inputs rr_ptr+1 .. rr_ptr+NUM_INPUTS for a non-empty FIFO,
//            register it as grant, go to XFER. Output tvalid is 0.
//     XFER : present the granted FIFO head; on the tlast beat, move rr_ptr
//            to the grant and return to PICK. The grant is never changed
//            mid-packet, so packets cannot interleave.
//   Latency: a word accepted at edge N is transferred out at edge N+2 when
//   the block is idle; one PICK bubble separates consecutive packets.
// ----------------------------------------------------------------------------
module input_rr_arbiter
  import input_rr_arbiter_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_INPUTS           = 5,
  parameter int FIFO_DEPTH_BITS      = 4
) (
  input  logic                                           axi_aclk,
  input  logic                                           axi_resetn,
  input  logic [NUM_INPUTS*C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [NUM_INPUTS*(C_S_AXIS_DATA_WIDTH/8)-1:0]  s_axis_tstrb,
  input  logic [NUM_INPUTS*C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic [NUM_INPUTS-1:0]                          s_axis_tvalid,
  output logic [NUM_INPUTS-1:0]                          s_axis_tready,
  input  logic [NUM_INPUTS-1:0]                          s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]                 m_axis_tdata,
  output logic [(C_M_AXIS_DATA_WIDTH/8)-1:0]             m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]                m_axis_tuser,
  output logic                                           m_axis_tvalid,
  input  logic                                           m_axis_tready,
  output logic                                           m_axis_tlast
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int SW = DW / 8;
  localparam int FW = fifo_word_width(DW, UW);

  // Reset value: rr_ptr points at the last input so input 0 is scanned first.
  localparam arb_regs_t ARB_RESET = '{
    state:  PICK,
    grant:  '0,
    rr_ptr: PORT_IDX_W'(NUM_INPUTS - 1)
  };

  // --------------------------------------------------------------------------
  // Input FIFOs
  // --------------------------------------------------------------------------
  logic [FW-1:0]         fifo_din  [NUM_INPUTS];
  logic [FW-1:0]         fifo_dout [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] fifo_wr_en;
  logic [NUM_INPUTS-1:0] fifo_rd_en;
  logic [NUM_INPUTS-1:0] fifo_empty;
  logic [NUM_INPUTS-1:0] fifo_nearly_full;
  logic                  fifo_reset;

  assign fifo_reset = ~axi_resetn;

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_in
    assign fifo_din[gi] = {s_axis_tlast[gi],
                           s_axis_tuser[gi*UW +: UW],
                           s_axis_tstrb[gi*SW +: SW],
                           s_axis_tdata[gi*DW +: DW]};

    // Ready is gated by reset so nothing is accepted while the FIFOs flush.
    assign s_axis_tready[gi] = ~fifo_nearly_full[gi] & axi_resetn;
    assign fifo_wr_en[gi]    = s_axis_tvalid[gi] & s_axis_tready[gi];

    fallthrough_small_fifo #(
      .WIDTH          (FW),
      .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk         (axi_aclk),
      .reset       (fifo_reset),
      .din         (fifo_din[gi]),
      .wr_en       (fifo_wr_en[gi]),
      .rd_en       (fifo_rd_en[gi]),
      .dout        (fifo_dout[gi]),
      .nearly_full (fifo_nearly_full[gi]),
      .empty       (fifo_empty[gi])
    );
  end

  // --------------------------------------------------------------------------
  // Arbiter registers (FSM state, grant, round-robin pointer)
  // --------------------------------------------------------------------------
  arb_regs_t               arb_q;
  arb_regs_t               arb_d;
  logic                    pick_found;
  logic [PORT_IDX_W-1:0]   pick_idx;
  logic [FW-1:0]           head;
  logic                    out_fire_last;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) arb_q <= ARB_RESET;
    else             arb_q <= arb_d;
  end

  // Round-robin search: first non-empty FIFO after rr_ptr, wrapping around.
  // The candidate index is reduced modulo NUM_INPUTS by a single subtract,
  // which is enough because rr_ptr < NUM_INPUTS and k <= NUM_INPUTS.
  always_comb begin
    int                    idx;
    logic [PORT_IDX_W-1:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    cand       = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      idx = int'(arb_q.rr_ptr) + k;
      if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
      cand = PORT_IDX_W'(idx);
      if (!pick_found && !fifo_empty[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign out_fire_last = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // Next-state logic
  always_comb begin
    arb_d = arb_q;
    case (arb_q.state)
      PICK: begin
        if (pick_found) begin
          arb_d.state = XFER;
          arb_d.grant = pick_idx;
        end
      end
      XFER: begin
        if (out_fire_last) begin
          arb_d.state  = PICK;
          arb_d.rr_ptr = arb_q.grant;
        end
      end
      default: arb_d = ARB_RESET;
    endcase
  end

  // Output logic: the granted FIFO head drives the output directly, so the
  // beat stays stable under backpressure until it is popped.
  always_comb begin
    head          = fifo_dout[arb_q.grant];
    m_axis_tdata  = head[DW-1:0];
    m_axis_tstrb  = head[DW +: SW];
    m_axis_tuser  = head[DW+SW +: UW];
    m_axis_tlast  = head[FW-1];
    m_axis_tvalid = (arb_q.state == XFER) & ~fifo_empty[arb_q.grant];
    fifo_rd_en    = '0;
    fifo_rd_en[arb_q.grant] = m_axis_tvalid & m_axis_tready;
  end

endmodule
